ula_seq: RTL
============

ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 SHALL have parameter W, default 8, operand/result width in bits.
REQ-002 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have req_valid, input, 1, upstream operation request valid.
REQ-005 SHALL have req_ready, output, 1, sequencer can accept a request.
REQ-006 SHALL have req_op, input, 4, ALU operation select.
REQ-007 SHALL have req_a and req_b, input, W each, operands.
REQ-008 SHALL have req_use_acc, input, 1, substitute accumulator for req_a.
REQ-009 SHALL have acc_clr, input, 1, clear accumulator.
REQ-010 SHALL have alu_a, alu_b, output, W each, and alu_s, output, 4, driving the combinational ALU.
REQ-011 SHALL have alu_out, input, W, combinational ALU result.
REQ-012 SHALL have rsp_valid, output, 1; rsp_ready, input, 1; rsp_data, output, W; rsp_zero, output, 1; rsp_err, output, 1.
REQ-013 SHALL have acc, output, W, current accumulator value.

Function
REQ-014 SHALL use FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-015 IDLE: req_ready=1; on req_valid&&req_ready, latch op, operands and use_acc into registers, go EXEC.
REQ-016 When use_acc=1, the latched A operand SHALL be acc as of the accept cycle; req_a is ignored.
REQ-017 alu_a/alu_b/alu_s SHALL be driven only from the latched registers, never from req_*, and hold stable through EXEC and DONE.
REQ-018 EXEC lasts exactly one cycle; at its end rsp_data<=alu_out, rsp_zero<=(alu_out==0), rsp_err<=(op>4'b0011); go DONE.
REQ-019 Latency: request accepted in cycle N SHALL produce rsp_valid=1 in cycle N+2.
REQ-020 DONE: rsp_valid=1, rsp_data/rsp_zero/rsp_err stable until rsp_valid&&rsp_ready; then go IDLE. req_ready=0 in EXEC and DONE.
REQ-021 Legal ops: 0000 add, 0001 sub (A-B, two's complement, wrap mod 2^W), 0010 AND, 0011 OR; all others illegal.
REQ-022 Accumulator SHALL load rsp_data at the EXEC->DONE transition only for legal ops; illegal ops leave acc unchanged.
REQ-023 acc_clr SHALL zero acc next cycle in any state; when it coincides with an EXEC->DONE load, clear wins.
REQ-024 acc_clr coinciding with an accept having use_acc=1 SHALL latch the pre-clear acc value.
REQ-025 Throughput: at most one operation per 3 cycles; back-to-back requests wait in upstream.

Reset
REQ-026 With rst_n=0 at a clock edge: state=IDLE, acc=0, latched op/operands=0, rsp_data=0, rsp_zero=0, rsp_err=0, rsp_valid=0.
REQ-027 Reset during EXEC or DONE SHALL abandon the operation with no response and no acc update.
REQ-028 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.

Structure
REQ-029 Package ula_pkg SHALL hold op codes OP_ADD, OP_SUB, OP_AND, OP_OR, the state enum type, and OP_LAST_LEGAL=4'b0011.
REQ-030 No sub-module; the ALU is instantiated alongside by the integrating level, connected through alu_* ports.

Verification
REQ-031 ADD req_a=0x05, req_b=0x03 accepted cycle N -> rsp_valid at N+2, rsp_data=0x08, rsp_zero=0, rsp_err=0, acc=0x08.
REQ-032 SUB 0x10-0x10 -> rsp_data=0x00, rsp_zero=1; SUB 0x00-0x01 -> rsp_data=0xFF (wrap).
REQ-033 acc=0x08, ADD use_acc=1, req_a=0x77, req_b=0x02 -> rsp_data=0x0A; op 4'b0111 -> rsp_data=0x00, rsp_err=1, acc stays 0x0A.
REQ-034 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid/rsp_data stable, req_ready=0, extra req_valid ignored; on rsp_ready=1 return IDLE next cycle.
REQ-035 rst_n=0 in EXEC -> next cycle IDLE, rsp_valid=0, acc=0; acc_clr in same cycle as EXEC->DONE -> acc=0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU request sequencer: op codes, legality
// helper and the sequencer state type.
package ula_pkg;

    localparam logic [3:0] OP_ADD        = 4'b0000;
    localparam logic [3:0] OP_SUB        = 4'b0001;
    localparam logic [3:0] OP_AND        = 4'b0010;
    localparam logic [3:0] OP_OR         = 4'b0011;
    localparam logic [3:0] OP_LAST_LEGAL = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/ula_seq.sv
// Sequencer around an external combinational ALU: accepts one request,
// drives the ALU from latched operands, returns the result and keeps an accumulator.
module ula_seq
    import ula_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_use_acc,
    input  logic         acc_clr,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_s,
    input  logic [W-1:0] alu_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [W-1:0] acc,
    output state_t       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; the producer holds its payload stable while valid && !ready.

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         accept;
    logic         finish;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rst_n gating keeps ready low during reset even if already IDLE
                req_ready = rst_n;
                accept    = req_valid && rst_n;
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                finish  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
            acc      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= req_op;
                // acc here is the pre-clear value even when acc_clr is high
                a_q  <= req_use_acc ? acc : req_a;
                b_q  <= req_b;
            end
            if (finish) begin
                rsp_data <= alu_out;
                rsp_zero <= (alu_out == '0);
                rsp_err  <= !op_legal(op_q);
            end
            if (acc_clr) begin
                acc <= '0;
            end else if (finish && op_legal(op_q)) begin
                acc <= alu_out;
            end
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_s     = op_q;
    assign dbg_state = state_q;

endmodule
